// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the receive path. The transmitter uses the same
// sample widths and word-select polarity.
//   WS_LEFT / WS_RIGHT   : word-select polarity (0 = left channel)
//   *_SAMPLE_BITS        : legal and default captured word widths
//   i2s_state_e          : receiver framing FSM encoding
package i2s_pkg;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int MAX_SAMPLE_BITS     = 32;
  localparam int MIN_SAMPLE_BITS     = 8;
  localparam int DEFAULT_SAMPLE_BITS = 16;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings the asynchronous I2S bit clock, word select and serial data into the
// fabric clock domain. It also produces a one-cycle strobe for each rising
// edge of the synchronised bit clock.
//   i_clk, i_rst : fabric clock and synchronous active-high reset
//   i_bclk       : external bit clock
//   i_ws, i_sd   : external word select and serial data
//   o_strobe     : high for one cycle after the synchronised bit clock rises
//   o_ws, o_sd   : synchronised WS/SD, aligned with o_strobe
module i2s_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bclk,
  input  logic i_ws,
  input  logic i_sd,
  output logic o_strobe,
  output logic o_ws,
  output logic o_sd
);

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_bclk_prev;

  // Synchroniser chains, plus the previous synchronised bit clock for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bclk_sync <= '0;
      r_ws_sync   <= '0;
      r_sd_sync   <= '0;
      r_bclk_prev <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
      r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], i_ws};
      r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], i_sd};
      r_bclk_prev <= r_bclk_sync[SYNC_STAGES-1];
    end
  end

  // WS and SD go through chains of the same depth as the bit clock, so they
  // are captured together with the edge that samples them.
  assign o_strobe = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
  assign o_ws     = r_ws_sync[SYNC_STAGES-1];
  assign o_sd     = r_sd_sync[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver. It oversamples the I2S bus on the fabric clock and
// deserialises MSB-first left and right words. Complete stereo pairs are
// presented over a valid/ready handshake.
//   i_clk, i_rst          : fabric clock (>= 4x bit clock), synchronous active-high reset
//   i_i2s_clk_in          : external bit clock
//   i_i2s_word_select_in  : external WS (0 = left, 1 = right)
//   i_i2s_data_in         : external serial data
//   o_sample_left/right   : captured pair in the holding register
//   o_sample_valid        : holding register full
//   i_sample_ready        : consumer takes the pair when valid && ready
//   o_overrun             : one-cycle pulse when a completed pair is dropped
//   o_short_word          : one-cycle pulse when a word closed with too few bits
//   o_locked              : set after the first completed pair
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = DEFAULT_SAMPLE_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_i2s_clk_in,
  input  logic                   i_i2s_word_select_in,
  input  logic                   i_i2s_data_in,
  output logic [SAMPLE_BITS-1:0] o_sample_left,
  output logic [SAMPLE_BITS-1:0] o_sample_right,
  output logic                   o_sample_valid,
  input  logic                   i_sample_ready,
  output logic                   o_overrun,
  output logic                   o_short_word,
  output logic                   o_locked
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam int IW = $clog2(SAMPLE_BITS);

  logic                   w_strobe;
  logic                   w_ws;
  logic                   w_sd;
  logic                   w_ws_change;
  logic [SAMPLE_BITS-1:0] w_word_next;
  logic [CW-1:0]          w_count_next;
  logic [IW-1:0]          w_bit_idx;
  logic                   w_short;
  i2s_state_e             w_state_next;

  i2s_state_e             r_state;
  logic                   r_ws_prev;
  logic                   r_ws_valid;
  logic [SAMPLE_BITS-1:0] r_shift;
  logic [CW-1:0]          r_count;
  logic [SAMPLE_BITS-1:0] r_left_word;
  logic [SAMPLE_BITS-1:0] r_right_word;
  logic                   r_left_have;
  logic                   r_pair_pending;
  logic [SAMPLE_BITS-1:0] r_sample_left;
  logic [SAMPLE_BITS-1:0] r_sample_right;
  logic                   r_sample_valid;
  logic                   r_overrun;
  logic                   r_short_word;
  logic                   r_locked;

  i2s_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_bclk  (i_i2s_clk_in),
    .i_ws    (i_i2s_word_select_in),
    .i_sd    (i_i2s_data_in),
    .o_strobe(w_strobe),
    .o_ws    (w_ws),
    .o_sd    (w_sd)
  );

  // No WS transition can be seen until one WS value has been recorded after reset.
  assign w_ws_change = r_ws_valid & (w_ws != r_ws_prev);
  assign w_bit_idx   = IW'(SAMPLE_BITS - 1) - IW'(r_count);
  assign w_short     = (w_count_next < CW'(SAMPLE_BITS));

  // Word value and count after placing the current SD bit MSB-first.
  // Bits beyond SAMPLE_BITS are ignored, and the count saturates.
  always_comb begin
    w_word_next  = r_shift;
    w_count_next = r_count;
    if (r_count < CW'(SAMPLE_BITS)) begin
      w_word_next[w_bit_idx] = w_sd;
      w_count_next           = r_count + CW'(1);
    end else begin
      w_count_next = r_count;
    end
  end

  // Framing next-state: a WS change on a strobe ends the current channel
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SYNC: begin
        if (w_strobe && w_ws_change) begin
          w_state_next = (w_ws == WS_RIGHT) ? RIGHT : LEFT;
        end else begin
          w_state_next = SYNC;
        end
      end
      LEFT: begin
        if (w_strobe && w_ws_change) begin
          w_state_next = RIGHT;
        end else begin
          w_state_next = LEFT;
        end
      end
      RIGHT: begin
        if (w_strobe && w_ws_change) begin
          w_state_next = LEFT;
        end else begin
          w_state_next = RIGHT;
        end
      end
      default: w_state_next = SYNC;
    endcase
  end

  // Framing state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Word accumulation, channel latching, pair hand-off and status pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ws_prev      <= 1'b0;
      r_ws_valid     <= 1'b0;
      r_shift        <= '0;
      r_count        <= '0;
      r_left_word    <= '0;
      r_right_word   <= '0;
      r_left_have    <= 1'b0;
      r_pair_pending <= 1'b0;
      r_sample_left  <= '0;
      r_sample_right <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_short_word   <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_overrun    <= 1'b0;
      r_short_word <= 1'b0;

      // A pair closed on the previous strobe is offered to the holding register.
      if (r_pair_pending) begin
        r_pair_pending <= 1'b0;
        r_locked       <= 1'b1;
        if (!r_sample_valid || i_sample_ready) begin
          r_sample_left  <= r_left_word;
          r_sample_right <= r_right_word;
          r_sample_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_sample_valid && i_sample_ready) begin
        r_sample_valid <= 1'b0;
      end

      if (w_strobe) begin
        r_ws_prev  <= w_ws;
        r_ws_valid <= 1'b1;
        if (w_ws_change) begin
          // This SD bit is the LSB of the channel that just ended.
          r_shift <= '0;
          r_count <= '0;
          case (r_state)
            LEFT: begin
              r_left_word  <= w_word_next;
              r_left_have  <= 1'b1;
              r_short_word <= w_short;
            end
            RIGHT: begin
              r_right_word   <= w_word_next;
              r_short_word   <= w_short;
              r_pair_pending <= r_left_have;
              r_left_have    <= 1'b0;
            end
            default: begin
              r_left_have <= 1'b0;
            end
          endcase
        end else if (r_state != SYNC) begin
          r_shift <= w_word_next;
          r_count <= w_count_next;
        end
      end
    end
  end

  assign o_sample_left  = r_sample_left;
  assign o_sample_right = r_sample_right;
  assign o_sample_valid = r_sample_valid;
  assign o_overrun      = r_overrun;
  assign o_short_word   = r_short_word;
  assign o_locked       = r_locked;

endmodule

// File: tb/tb_i2s_receiver.sv
// Testbench for i2s_receiver. It drives I2S frames at bclk = clk/8 and queues
// the expected pair for every frame that should be delivered. Pairs are popped
// and compared whenever the receiver hands one over.
module tb_i2s_receiver;
  import i2s_pkg::*;

  localparam int SB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b0;
  logic          ws = 1'b0;
  logic          sd = 1'b0;
  logic          sample_ready = 1'b0;
  logic [SB-1:0] sample_left;
  logic [SB-1:0] sample_right;
  logic          sample_valid;
  logic          overrun;
  logic          short_word;
  logic          locked;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_ovr   = 0;
  int n_short = 0;

  logic [31:0] q_left[$];
  logic [31:0] q_right[$];

  i2s_receiver #(
    .SAMPLE_BITS(SB),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_i2s_clk_in        (bclk),
    .i_i2s_word_select_in(ws),
    .i_i2s_data_in       (sd),
    .o_sample_left       (sample_left),
    .o_sample_right      (sample_right),
    .o_sample_valid      (sample_valid),
    .i_sample_ready      (sample_ready),
    .o_overrun           (overrun),
    .o_short_word        (short_word),
    .o_locked            (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected capture of an n-bit word: truncate the extra LSBs or zero-pad.
  function automatic logic [31:0] exp_word(input logic [31:0] v, input int n);
    logic [31:0] m;
    m = (n >= 32) ? v : (v & ((32'd1 << n) - 32'd1));
    if (n >= SB) return (m >> (n - SB)) & 32'h0000_FFFF;
    else         return (m << (SB - n)) & 32'h0000_FFFF;
  endfunction

  // Consumer side: sample away from the active edge and count status pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) n_ovr++;
      if (short_word) n_short++;
      if (sample_valid && sample_ready) begin
        n_acc++;
        if (q_left.size() == 0) begin
          check("unexpected_pair", 32'd1, 32'd0);
        end else begin
          check("pair_left", {16'd0, sample_left}, q_left.pop_front());
          check("pair_right", {16'd0, sample_right}, q_right.pop_front());
        end
      end
    end
  end

  task automatic send_bit(input logic w, input logic d);
    ws   = w;
    sd   = d;
    bclk = 1'b0;
    #40;
    bclk = 1'b1;
    #40;
  endtask

  // Tail of a right word: ends with the WS flip to left on the right LSB.
  task automatic lead_in(input int n);
    repeat (n) send_bit(WS_RIGHT, 1'($urandom_range(0, 1)));
    send_bit(WS_LEFT, 1'($urandom_range(0, 1)));
  endtask

  // One I2S frame: WS flips on the LSB slot of each channel.
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit expect_it);
    if (expect_it) begin
      q_left.push_back(exp_word(l, n));
      q_right.push_back(exp_word(r, n));
    end
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? WS_RIGHT : WS_LEFT, l[i]);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? WS_LEFT : WS_RIGHT, r[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 sample_ready = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    q_left.delete();
    q_right.delete();
    n_acc   = 0;
    n_ovr   = 0;
    n_short = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check("rst_left", {16'd0, sample_left}, 32'd0);
    check("rst_right", {16'd0, sample_right}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_short", {31'd0, short_word}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_state", {30'd0, dut.r_state}, {30'd0, SYNC});
    #1 rst = 1'b0;

    // Test 1 and Test 5 (mid-right start): basic pairs, ready held high
    do_reset();
    set_ready(1'b1);
    lead_in(7);
    idle(10);
    check("t1_unlocked_before_frame", {31'd0, locked}, 32'd0);
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
    idle(10);
    check("t1_locked", {31'd0, locked}, 32'd1);
    check("t1_acc_first", n_acc, 32'd1);
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
    idle(10);
    check("t1_acc_total", n_acc, 32'd3);
    check("t1_short", n_short, 32'd0);
    check("t1_queue_empty", q_left.size(), 32'd0);

    // Test 2: 24-bit words truncated
    do_reset();
    lead_in(3);
    send_frame(32'hABCDEF, 32'h123456, 24, 1'b1);
    send_frame(32'h5A5A5A, 32'hC3C3C3, 24, 1'b1);
    idle(10);
    check("t2_acc", n_acc, 32'd2);
    check("t2_short", n_short, 32'd0);

    // Test 3: 12-bit words zero-padded
    do_reset();
    lead_in(3);
    send_frame(32'hFFF, 32'h801, 12, 1'b1);
    send_frame(32'hFFF, 32'h801, 12, 1'b1);
    idle(10);
    check("t3_acc", n_acc, 32'd2);
    check("t3_short", n_short, 32'd4);

    // Test 4: backpressure for three frames
    do_reset();
    set_ready(1'b0);
    lead_in(3);
    send_frame(32'h0001, 32'h0100, 16, 1'b1);
    send_frame(32'h0002, 32'h0200, 16, 1'b0);
    send_frame(32'h0003, 32'h0300, 16, 1'b0);
    idle(10);
    check("t4_overrun", n_ovr, 32'd2);
    check("t4_valid_held", {31'd0, sample_valid}, 32'd1);
    check("t4_left_held", {16'd0, sample_left}, 32'h0001);
    check("t4_right_held", {16'd0, sample_right}, 32'h0100);
    check("t4_acc_none", n_acc, 32'd0);
    set_ready(1'b1);
    idle(4);
    check("t4_acc_held", n_acc, 32'd1);
    send_frame(32'h0004, 32'h0400, 16, 1'b1);
    idle(10);
    check("t4_acc_after", n_acc, 32'd2);
    check("t4_queue_empty", q_left.size(), 32'd0);

    // Test 5b: start in a left word, so the orphan right word yields nothing
    do_reset();
    repeat (5) send_bit(WS_LEFT, 1'b1);
    send_bit(WS_RIGHT, 1'b1);
    for (int i = 15; i >= 0; i--) send_bit((i == 0) ? WS_LEFT : WS_RIGHT, 1'b1);
    idle(10);
    check("t5_no_pair", n_acc, 32'd0);
    check("t5_unlocked", {31'd0, locked}, 32'd0);
    send_frame(32'h3C5A, 32'h96E1, 16, 1'b1);
    idle(10);
    check("t5_acc", n_acc, 32'd1);

    // Test 6: one-cycle reset in the middle of a left word
    do_reset();
    set_ready(1'b0);
    lead_in(3);
    send_frame(32'h7777, 32'h8888, 16, 1'b1);
    for (int i = 15; i >= 8; i--) send_bit(WS_LEFT, 1'b1);
    idle(4);
    check("t6_valid_before", {31'd0, sample_valid}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q_left.delete();
    q_right.delete();
    @(negedge clk);
    check("t6_left", {16'd0, sample_left}, 32'd0);
    check("t6_right", {16'd0, sample_right}, 32'd0);
    check("t6_valid", {31'd0, sample_valid}, 32'd0);
    check("t6_locked", {31'd0, locked}, 32'd0);
    check("t6_state", {30'd0, dut.r_state}, {30'd0, SYNC});
    set_ready(1'b1);
    n_acc = 0;
    for (int i = 7; i >= 0; i--) send_bit((i == 0) ? WS_RIGHT : WS_LEFT, 1'b1);
    for (int i = 15; i >= 0; i--) send_bit((i == 0) ? WS_LEFT : WS_RIGHT, 1'b0);
    send_frame(32'hBEEF, 32'hCAFE, 16, 1'b1);
    idle(10);
    check("t6_acc", n_acc, 32'd1);
    check("t6_locked_after", {31'd0, locked}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
